// File: rtl/mult_div_if.sv
// mult_div_if: operand/result bundle between the control unit and mult_div_unit.
//   start, div_or_mult, a, b    : operation request (control unit -> unit)
//   hi_out, lo_out              : results headed for the HI/LO registers
//   busy, done, div_zero        : status back to the control unit
interface mult_div_if;
   logic        start;
   logic        div_or_mult;
   logic [31:0] a;
   logic [31:0] b;
   logic [31:0] hi_out;
   logic [31:0] lo_out;
   logic        busy;
   logic        done;
   logic        div_zero;

   modport master (
      output start, div_or_mult, a, b,
      input  hi_out, lo_out, busy, done, div_zero
   );

   modport slave (
      input  start, div_or_mult, a, b,
      output hi_out, lo_out, busy, done, div_zero
   );
endinterface

// File: rtl/mult_div_unit.sv
// mult_div_unit: multicycle signed 32x32 multiply (radix-2 Booth, 32 cycles)
// and signed divide (restoring on magnitudes + sign fix, 33 cycles).
// Ports:
//   clock  : rising-edge clock
//   reset  : asynchronous active-low reset
//   bus    : mult_div_if.slave (start/div_or_mult/a/b in; hi_out/lo_out/busy/done/div_zero out)
// A divide by zero stays in IDLE and reports done+div_zero one edge after start,
// leaving hi_out/lo_out untouched.
module mult_div_unit (
   input  logic       clock,
   input  logic       reset,
   mult_div_if.slave  bus
);
   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_MULT = 2'd1,
      ST_DIV  = 2'd2,
      ST_FIX  = 2'd3
   } state_t;

   // Absolute value; 0x80000000 maps to itself, read as unsigned 2^31.
   function automatic logic [31:0] magnitude(input logic [31:0] v);
      magnitude = v[31] ? (32'd0 - v) : v;
   endfunction

   function automatic logic [31:0] cond_negate(input logic [31:0] v, input logic neg);
      cond_negate = neg ? (32'd0 - v) : v;
   endfunction

   state_t      state_r, state_s;
   logic [5:0]  cnt_r, cnt_s;
   logic [31:0] mcand_r, mcand_s;
   logic [31:0] acc_r, acc_s;
   logic [31:0] mplier_r, mplier_s;
   logic        qm1_r, qm1_s;
   logic [32:0] dsor_r, dsor_s;
   logic [32:0] rem_r, rem_s;
   logic [31:0] quo_r, quo_s;
   logic        sign_q_r, sign_q_s;
   logic        sign_r_r, sign_r_s;
   logic        dz_pend_r, dz_pend_s;
   logic [31:0] hi_r, hi_s;
   logic [31:0] lo_r, lo_s;
   logic        busy_r, busy_s;
   logic        done_r, done_s;
   logic        div_zero_r, div_zero_s;

   logic [32:0] booth_sum_s;
   logic [32:0] rem_sh_s;
   logic [32:0] trial_s;

   // Next-state, datapath and output computation.
   always_comb begin
      state_s    = state_r;
      cnt_s      = cnt_r;
      mcand_s    = mcand_r;
      acc_s      = acc_r;
      mplier_s   = mplier_r;
      qm1_s      = qm1_r;
      dsor_s     = dsor_r;
      rem_s      = rem_r;
      quo_s      = quo_r;
      sign_q_s   = sign_q_r;
      sign_r_s   = sign_r_r;
      dz_pend_s  = 1'b0;
      hi_s       = hi_r;
      lo_s       = lo_r;
      busy_s     = busy_r;
      done_s     = 1'b0;
      div_zero_s = div_zero_r;

      // Booth add is done 33 bits wide so that acc - M cannot overflow
      // before the arithmetic shift (e.g. 0 - 0x80000000).
      case ({mplier_r[0], qm1_r})
         2'b01:   booth_sum_s = {acc_r[31], acc_r} + {mcand_r[31], mcand_r};
         2'b10:   booth_sum_s = {acc_r[31], acc_r} - {mcand_r[31], mcand_r};
         default: booth_sum_s = {acc_r[31], acc_r};
      endcase

      // Restoring step: rem < divisor <= 2^31, so the shifted value fits in
      // 32 bits and bit 32 of the trial difference is its sign.
      rem_sh_s = {rem_r[31:0], quo_r[31]};
      trial_s  = rem_sh_s - dsor_r;

      case (state_r)
         ST_IDLE: begin
            if (dz_pend_r) begin
               done_s     = 1'b1;
               div_zero_s = 1'b1;
            end else if (bus.start) begin
               div_zero_s = 1'b0;
               cnt_s      = 6'd0;
               mcand_s    = bus.a;
               acc_s      = 32'd0;
               mplier_s   = bus.b;
               qm1_s      = 1'b0;
               dsor_s     = {1'b0, magnitude(bus.b)};
               rem_s      = 33'd0;
               quo_s      = magnitude(bus.a);
               sign_q_s   = bus.a[31] ^ bus.b[31];
               sign_r_s   = bus.a[31];
               if (!bus.div_or_mult) begin
                  state_s = ST_MULT;
                  busy_s  = 1'b1;
               end else if (bus.b == 32'd0) begin
                  dz_pend_s = 1'b1;
               end else begin
                  state_s = ST_DIV;
                  busy_s  = 1'b1;
               end
            end else begin
               state_s = ST_IDLE;
            end
         end
         ST_MULT: begin
            cnt_s    = cnt_r + 6'd1;
            acc_s    = booth_sum_s[32:1];
            mplier_s = {booth_sum_s[0], mplier_r[31:1]};
            qm1_s    = mplier_r[0];
            if (cnt_r == 6'd31) begin
               hi_s    = booth_sum_s[32:1];
               lo_s    = {booth_sum_s[0], mplier_r[31:1]};
               done_s  = 1'b1;
               busy_s  = 1'b0;
               state_s = ST_IDLE;
            end else begin
               state_s = ST_MULT;
            end
         end
         ST_DIV: begin
            cnt_s = cnt_r + 6'd1;
            if (trial_s[32]) begin
               rem_s = rem_sh_s;
               quo_s = {quo_r[30:0], 1'b0};
            end else begin
               rem_s = trial_s;
               quo_s = {quo_r[30:0], 1'b1};
            end
            if (cnt_r == 6'd31) begin
               state_s = ST_FIX;
            end else begin
               state_s = ST_DIV;
            end
         end
         ST_FIX: begin
            lo_s    = cond_negate(quo_r, sign_q_r);
            hi_s    = cond_negate(rem_r[31:0], sign_r_r);
            done_s  = 1'b1;
            busy_s  = 1'b0;
            state_s = ST_IDLE;
         end
         default: begin
            busy_s  = 1'b0;
            state_s = ST_IDLE;
         end
      endcase
   end

   // State, datapath and output registers.
   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         state_r    <= ST_IDLE;
         cnt_r      <= 6'd0;
         mcand_r    <= 32'd0;
         acc_r      <= 32'd0;
         mplier_r   <= 32'd0;
         qm1_r      <= 1'b0;
         dsor_r     <= 33'd0;
         rem_r      <= 33'd0;
         quo_r      <= 32'd0;
         sign_q_r   <= 1'b0;
         sign_r_r   <= 1'b0;
         dz_pend_r  <= 1'b0;
         hi_r       <= 32'd0;
         lo_r       <= 32'd0;
         busy_r     <= 1'b0;
         done_r     <= 1'b0;
         div_zero_r <= 1'b0;
      end else begin
         state_r    <= state_s;
         cnt_r      <= cnt_s;
         mcand_r    <= mcand_s;
         acc_r      <= acc_s;
         mplier_r   <= mplier_s;
         qm1_r      <= qm1_s;
         dsor_r     <= dsor_s;
         rem_r      <= rem_s;
         quo_r      <= quo_s;
         sign_q_r   <= sign_q_s;
         sign_r_r   <= sign_r_s;
         dz_pend_r  <= dz_pend_s;
         hi_r       <= hi_s;
         lo_r       <= lo_s;
         busy_r     <= busy_s;
         done_r     <= done_s;
         div_zero_r <= div_zero_s;
      end
   end

   assign bus.hi_out   = hi_r;
   assign bus.lo_out   = lo_r;
   assign bus.busy     = busy_r;
   assign bus.done     = done_r;
   assign bus.div_zero = div_zero_r;
endmodule

// File: tb/tb_mult_div_unit.sv
// tb_mult_div_unit: directed vectors for mult_div_unit with hand-computed results.
module tb_mult_div_unit;
   logic clock;
   logic reset;
   int   n_cmp;
   int   n_err;

   mult_div_if bus_if();

   mult_div_unit dut (
      .clock (clock),
      .reset (reset),
      .bus   (bus_if)
   );

   initial clock = 1'b0;
   always #5 clock = ~clock;

   task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp = n_cmp + 1;
      if (obs !== exp) begin
         n_err = n_err + 1;
         $display("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
      end
   endtask

   // Issue one operation starting now, then follow it to done.
   // inject > 0 pulses a start with bogus operands after that many edges.
   task automatic run_op(input string tag, input logic div, input logic [31:0] a,
                         input logic [31:0] b, input int exp_lat, input logic [31:0] exp_hi,
                         input logic [31:0] exp_lo, input logic exp_dz, input int inject);
      int lat;
      int busy_cnt;
      lat      = 0;
      busy_cnt = 0;
      bus_if.start       = 1'b1;
      bus_if.div_or_mult = div;
      bus_if.a           = a;
      bus_if.b           = b;
      @(posedge clock);
      #1;
      bus_if.start = 1'b0;
      bus_if.a     = 32'h5A5A_A5A5;
      bus_if.b     = 32'h0000_0000;
      check_val({tag, "_busy_e0"}, {31'd0, bus_if.busy}, {31'd0, ~exp_dz});
      for (int i = 1; i <= 40; i++) begin
         @(posedge clock);
         #1;
         if (bus_if.done) begin
            lat = i;
            break;
         end
         if (bus_if.busy) busy_cnt = busy_cnt + 1;
         if (i == inject) begin
            bus_if.start       = 1'b1;
            bus_if.div_or_mult = 1'b1;
            bus_if.a           = 32'd100;
            bus_if.b           = 32'd0;
         end else begin
            bus_if.start = 1'b0;
         end
      end
      bus_if.start = 1'b0;
      check_val({tag, "_latency"}, 32'(lat), 32'(exp_lat));
      check_val({tag, "_busy_cycles"}, 32'(busy_cnt), exp_dz ? 32'd0 : 32'(exp_lat - 1));
      check_val({tag, "_busy_done"}, {31'd0, bus_if.busy}, 32'd0);
      check_val({tag, "_hi"}, bus_if.hi_out, exp_hi);
      check_val({tag, "_lo"}, bus_if.lo_out, exp_lo);
      check_val({tag, "_div_zero"}, {31'd0, bus_if.div_zero}, {31'd0, exp_dz});
   endtask

   initial begin
      logic done_seen;
      n_cmp = 0;
      n_err = 0;
      bus_if.start       = 1'b0;
      bus_if.div_or_mult = 1'b0;
      bus_if.a           = 32'd0;
      bus_if.b           = 32'd0;
      reset = 1'b0;
      #1;
      check_val("rst_hi", bus_if.hi_out, 32'd0);
      check_val("rst_lo", bus_if.lo_out, 32'd0);
      check_val("rst_flags", {29'd0, bus_if.busy, bus_if.done, bus_if.div_zero}, 32'd0);
      repeat (2) @(negedge clock);
      reset = 1'b1;
      @(negedge clock);

      run_op("mul_7xm3", 1'b0, 32'd7, 32'hFFFF_FFFD, 32, 32'hFFFF_FFFF, 32'hFFFF_FFEB, 1'b0, 0);
      @(posedge clock);
      #1;
      check_val("done_one_cycle", {31'd0, bus_if.done}, 32'd0);
      check_val("hold_lo", bus_if.lo_out, 32'hFFFF_FFEB);

      // Each following call raises start inside the previous done cycle.
      run_op("mul_min_sq", 1'b0, 32'h8000_0000, 32'h8000_0000, 32, 32'h4000_0000, 32'h0000_0000, 1'b0, 0);
      run_op("mul_m1_sq", 1'b0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32, 32'h0000_0000, 32'h0000_0001, 1'b0, 0);
      run_op("mul_2x3", 1'b0, 32'd2, 32'd3, 32, 32'h0000_0000, 32'h0000_0006, 1'b0, 0);
      run_op("div_9by0", 1'b1, 32'd9, 32'd0, 1, 32'h0000_0000, 32'h0000_0006, 1'b1, 0);
      run_op("div_7by2", 1'b1, 32'd7, 32'd2, 33, 32'h0000_0001, 32'h0000_0003, 1'b0, 0);
      run_op("div_m7by2", 1'b1, 32'hFFFF_FFF9, 32'd2, 33, 32'hFFFF_FFFF, 32'hFFFF_FFFD, 1'b0, 0);
      run_op("div_7bym2", 1'b1, 32'd7, 32'hFFFF_FFFE, 33, 32'h0000_0001, 32'hFFFF_FFFD, 1'b0, 0);
      run_op("div_min_by_m1", 1'b1, 32'h8000_0000, 32'hFFFF_FFFF, 33, 32'h0000_0000, 32'h8000_0000, 1'b0, 0);
      run_op("div_5by7", 1'b1, 32'd5, 32'd7, 33, 32'h0000_0005, 32'h0000_0000, 1'b0, 0);
      run_op("mul_busy_start", 1'b0, 32'd4, 32'd5, 32, 32'h0000_0000, 32'h0000_0014, 1'b0, 10);

      // Reset in cycle 15 of a divide: outputs clear at once, no done follows.
      @(negedge clock);
      bus_if.start       = 1'b1;
      bus_if.div_or_mult = 1'b1;
      bus_if.a           = 32'd100;
      bus_if.b           = 32'd7;
      @(posedge clock);
      #1;
      bus_if.start = 1'b0;
      repeat (14) @(posedge clock);
      #1;
      reset = 1'b0;
      #1;
      check_val("abort_hi", bus_if.hi_out, 32'd0);
      check_val("abort_lo", bus_if.lo_out, 32'd0);
      check_val("abort_flags", {29'd0, bus_if.busy, bus_if.done, bus_if.div_zero}, 32'd0);
      repeat (2) @(negedge clock);
      reset = 1'b1;
      done_seen = 1'b0;
      for (int i = 0; i < 40; i++) begin
         @(negedge clock);
         if (bus_if.done) done_seen = 1'b1;
      end
      check_val("abort_no_done", {31'd0, done_seen}, 32'd0);

      run_op("mul_after_rst", 1'b0, 32'hFFFF_FFFF, 32'd5, 32, 32'hFFFF_FFFF, 32'hFFFF_FFFB, 1'b0, 0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end
endmodule
